sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 181 ++++++++++++++++++
 tb/tb_sram_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// sram_responder: single-outstanding, fixed-latency SRAM responder.
//
// A request is accepted in IDLE, the responder waits LATENCY cycles and then
// presents a response that is held until the initiator takes it.
//
// Handshake rules (both channels): a transfer happens on a posedge where
// valid & ready are both 1. req_ready depends only on state and rst, never
// on req_valid. resp_valid depends only on state, never on resp_ready. Once
// resp_valid is 1 it stays 1, with resp_rdata and resp_err stable, until the
// transfer.
//
// Parameters
//   ADDR_WIDTH  word-index bits; storage is 2**ADDR_WIDTH 32-bit words
//   LATENCY     cycles from accept edge to resp_valid rising (1..15)
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_addr                 byte address, bits [1:0] ignored
//   req_wen                  1 = write, 0 = read
//   req_wdata, req_wmask     write data and byte-lane strobes
//   resp_valid / resp_ready  response handshake
//   resp_rdata               read word (0 for writes and out-of-range)
//   resp_err                 address beyond storage
//   dbg_state_o              current FSM state, for observation only
module sram_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbg_state_o
);

   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_WAIT   = 2'd1;
   localparam logic [1:0]  S_RESP   = 2'd2;
   localparam int          DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
   localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

   logic [31:0] mem [DEPTH];

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [29:0] idx_q, idx_d;
   logic        wen_q, wen_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic                  accept;
   logic                  enter_resp;
   logic [29:0]           acc_idx;
   logic                  acc_wen;
   logic [31:0]           acc_wdata;
   logic [3:0]            acc_wmask;
   logic                  acc_in_range;
   logic [ADDR_WIDTH-1:0] mem_idx;
   logic                  unused_addr_lsb;

   assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

   assign req_ready   = (state_q == S_IDLE) && !rst;
   assign resp_valid  = (state_q == S_RESP);
   assign resp_rdata  = rdata_q;
   assign resp_err    = err_q;
   assign dbg_state_o = state_q;

   assign accept = req_valid && req_ready;

   // With LATENCY 1 the access happens on the accept edge itself, so the
   // live request fields are used; otherwise the latched copy is used.
   assign enter_resp = (state_q == S_IDLE && accept && LATENCY == 1) ||
                       (state_q == S_WAIT && cnt_q == 4'd1);

   always_comb begin
      if (state_q == S_IDLE) begin
         acc_idx   = req_addr[31:2];
         acc_wen   = req_wen;
         acc_wdata = req_wdata;
         acc_wmask = req_wmask;
      end else begin
         acc_idx   = idx_q;
         acc_wen   = wen_q;
         acc_wdata = wdata_q;
         acc_wmask = wmask_q;
      end
   end

   assign acc_in_range = ({2'b00, acc_idx} < DEPTH_W);
   assign mem_idx      = acc_idx[ADDR_WIDTH-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               idx_d   = req_addr[31:2];
               wen_d   = req_wen;
               wdata_d = req_wdata;
               wmask_d = req_wmask;
               cnt_d   = LAT_LOAD;
               state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Response payload is captured once, on the edge entering RESP, and
      // then held untouched until the next access.
      if (enter_resp) begin
         err_d   = !acc_in_range;
         rdata_d = (!acc_wen && acc_in_range) ? mem[mem_idx] : 32'h0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= 30'd0;
         wen_q   <= 1'b0;
         wdata_q <= 32'h0;
         wmask_q <= 4'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage has no reset. A write only lands on the edge entering RESP, so
   // a request abandoned by reset in WAIT never reaches memory.
   always_ff @(posedge clk) begin
      if (enter_resp && acc_wen && acc_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_wmask[i]) begin
               mem[mem_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: instance u_dut (LATENCY 2) is driven by random
// and directed transactions and checked every cycle against a transaction
// level model; instance u_dut1 (LATENCY 1) is run back-to-back.
module tb_sram_responder;

   localparam int AW    = 10;
   localparam int LAT_A = 2;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance A signals
   logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
   logic [31:0] req_addr, req_wdata, resp_rdata;
   logic [3:0]  req_wmask;
   logic [1:0]  dbg_a;

   // instance B signals
   logic        b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_ready, b_resp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
   logic [3:0]  b_req_wmask;
   logic [1:0]  dbg_b;

   sram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT_A)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state_o(dbg_a)
   );

   sram_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
      .req_wen(b_req_wen), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .dbg_state_o(dbg_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model of instance A ----------------
   // A request is outstanding from its accept edge; after LAT_A edges the
   // response must be visible and stay until taken. The access result is
   // decided at that moment from the model memory.
   logic [31:0] mem_m [1024];
   bit          m_busy = 0;
   int          m_age  = 0;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wmask;
   logic        m_wen, m_err;

   task automatic m_commit();
      logic [29:0] idx;
      bit inr;
      idx   = m_addr[31:2];
      inr   = (idx < 30'd1024);
      m_err = !inr;
      if (m_wen) begin
         m_rdata = 32'h0;
         if (inr) begin
            for (int b = 0; b < 4; b++)
               if (m_wmask[b]) mem_m[idx[9:0]][8*b +: 8] = m_wdata[8*b +: 8];
         end
      end else begin
         m_rdata = inr ? mem_m[idx[9:0]] : 32'h0;
      end
   endtask

   // Inputs change 1 time unit after posedge, so at negedge both the DUT
   // outputs and the inputs the next edge will see are settled.
   always @(negedge clk) begin
      bit exp_v;
      if (rst) begin
         m_busy = 0;
         m_age  = 0;
         chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
         chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
         chk("rst_resp_rdata", resp_rdata, 32'h0);
         chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
      end else begin
         exp_v = m_busy && (m_age >= LAT_A);
         chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
         chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_v});
         if (exp_v) begin
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("resp_err", {31'b0, resp_err}, {31'b0, m_err});
         end
         if (m_busy) begin
            if (exp_v) begin
               if (resp_ready) m_busy = 0;
            end else begin
               m_age++;
               if (m_age >= LAT_A) m_commit();
            end
         end else if (req_valid) begin
            m_busy  = 1;
            m_age   = 1;
            m_addr  = req_addr;
            m_wen   = req_wen;
            m_wdata = req_wdata;
            m_wmask = req_wmask;
            if (m_age >= LAT_A) m_commit();
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic scramble();
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wen   = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      req_wmask = 4'($urandom_range(0, 15));
   endtask

   task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] m, input int stall,
                       output logic [31:0] got_d, output logic got_e, output int lat);
      int t;
      got_d = 32'h0; got_e = 1'b0; lat = 0;
      req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
      req_valid = 1'b1; resp_ready = 1'b0;
      t = 0;
      while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (!req_ready) begin
         chk("accept_timeout", 32'h0, 32'h1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      t = 0;
      while (!resp_valid && t < 50) begin scramble(); @(posedge clk); #1; t++; end
      if (!resp_valid) begin
         chk("resp_timeout", 32'h0, 32'h1);
         req_valid = 1'b0;
         return;
      end
      lat = t + 1;
      repeat (stall) begin scramble(); @(posedge clk); #1; end
      got_d = resp_rdata;
      got_e = resp_err;
      resp_ready = 1'b1;
      scramble();
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
   endtask

   // watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] gd, a;
      logic        ge;
      int          lat, idx;
      logic [31:0] exp_q [$];
      logic [31:0] b_addr [8];
      logic [31:0] b_data [8];
      int          k, nresp, last_cyc, cyc;

      rst = 1'b1;
      req_valid = 0; req_addr = 0; req_wen = 0; req_wdata = 0; req_wmask = 0; resp_ready = 0;
      b_req_valid = 0; b_req_addr = 0; b_req_wen = 0; b_req_wdata = 0; b_req_wmask = 4'hF;
      b_resp_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_req_ready", {31'b0, req_ready}, 32'h0);
      chk("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
      chk("reset_rdata", resp_rdata, 32'h0);
      chk("reset_err", {31'b0, resp_err}, 32'h0);
      rst = 1'b0;
      #1;
      chk("post_reset_req_ready", {31'b0, req_ready}, 32'h1);

      // prefill words 0..31 so every later in-range read is defined
      for (int i = 0; i < 32; i++)
         send(32'(i * 4), 1'b1, $urandom, 4'hF, 0, gd, ge, lat);

      // write then read back, checking latency
      send(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, gd, ge, lat);
      chk("w10_latency", 32'(lat), 32'd2);
      chk("w10_rdata", gd, 32'h0);
      chk("w10_err", {31'b0, ge}, 32'h0);
      send(32'h10, 1'b0, 32'h0, 4'h0, 0, gd, ge, lat);
      chk("r10_rdata", gd, 32'hDEADBEEF);

      // partial byte write; low address bits ignored
      send(32'h40, 1'b1, 32'h11223344, 4'hF, 0, gd, ge, lat);
      send(32'h41, 1'b1, 32'hAABBCCDD, 4'h5, 1, gd, ge, lat);
      send(32'h43, 1'b0, 32'h0, 4'h0, 0, gd, ge, lat);
      chk("mask5_rdata", gd, 32'h11BB33DD);

      // wmask 0 still responds and leaves memory alone
      send(32'h40, 1'b1, 32'hFFFFFFFF, 4'h0, 0, gd, ge, lat);
      chk("mask0_err", {31'b0, ge}, 32'h0);
      send(32'h40, 1'b0, 32'h0, 4'h0, 0, gd, ge, lat);
      chk("mask0_rdata", gd, 32'h11BB33DD);

      // long-held response; ready returns the cycle after the handshake
      send(32'h10, 1'b0, 32'h0, 4'h0, 5, gd, ge, lat);
      chk("stall_rdata", gd, 32'hDEADBEEF);
      chk("stall_ready_after", {31'b0, req_ready}, 32'h1);

      // out of range write, then index 0 unchanged
      send(32'h0, 1'b1, 32'h0BADF00D, 4'hF, 0, gd, ge, lat);
      send(32'h1000, 1'b1, 32'h12345678, 4'hF, 0, gd, ge, lat);
      chk("oor_err", {31'b0, ge}, 32'h1);
      chk("oor_rdata", gd, 32'h0);
      send(32'h0, 1'b0, 32'h0, 4'h0, 0, gd, ge, lat);
      chk("idx0_rdata", gd, 32'h0BADF00D);
      chk("idx0_err", {31'b0, ge}, 32'h0);

      // reset during WAIT abandons the write
      send(32'h20, 1'b1, 32'h0, 4'hF, 0, gd, ge, lat);
      req_addr = 32'h20; req_wen = 1'b1; req_wdata = 32'h55555555; req_wmask = 4'hF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
      chk("midrst_rdata", resp_rdata, 32'h0);
      chk("midrst_err", {31'b0, resp_err}, 32'h0);
      chk("midrst_req_ready", {31'b0, req_ready}, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("after_rst_ready", {31'b0, req_ready}, 32'h1);
      send(32'h20, 1'b0, 32'h0, 4'h0, 0, gd, ge, lat);
      chk("abandoned_write", gd, 32'h0);

      // random traffic, checked by the model
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0) idx = 1024 + $urandom_range(0, 5000);
         else idx = $urandom_range(0, 31);
         a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
         send(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), gd, ge, lat);
      end

      // LATENCY 1 instance: back-to-back writes then reads, ready held high
      for (int i = 0; i < 4; i++) begin
         b_addr[i]     = 32'((3 * i + 2) * 4);
         b_data[i]     = $urandom;
         b_addr[7 - i] = b_addr[i];
         b_data[7 - i] = b_data[i];
      end
      b_resp_ready = 1'b1;
      k = 0; nresp = 0; last_cyc = 0;
      for (cyc = 0; cyc < 100 && nresp < 8; cyc++) begin
         @(negedge clk);
         if (b_resp_valid) begin
            if (exp_q.size() == 0) chk("b_unexpected_resp", 32'h1, 32'h0);
            else chk("b_rdata", b_resp_rdata, exp_q.pop_front());
            chk("b_err", {31'b0, b_resp_err}, 32'h0);
            if (nresp > 0) chk("b_resp_gap", 32'(cyc - last_cyc), 32'd2);
            last_cyc = cyc;
            nresp++;
         end
         if (b_req_ready) begin
            if (k < 8) begin
               b_req_valid = 1'b1;
               b_req_wen   = (k < 4);
               b_req_addr  = b_addr[k];
               b_req_wdata = b_data[k];
               exp_q.push_back((k < 4) ? 32'h0 : b_data[k]);
               k++;
            end else begin
               b_req_valid = 1'b0;
            end
         end
      end
      chk("b_resp_count", 32'(nresp), 32'd8);
      b_req_valid = 1'b0;
      b_resp_ready = 1'b0;

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
